// File: rtl/fetch_engine.sv
// fetch_engine: weight/activation byte fetcher feeding matrix_core.
// Optional FETCH_ENGINE_PERF_EN adds a saturating stream-stall counter.
module fetch_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int W_DEPTH    = 16,
    parameter int X_DEPTH    = 4,
    parameter int MEM_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_vld,
    output logic                  cmd_rdy,
    input  logic [ADDR_WIDTH-1:0] cmd_w_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_x_addr,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  src_vld,
    input  logic                  src_rdy,
    output logic [DATA_WIDTH-1:0] src_data,
    output logic                  busy,
    output logic                  done
`ifdef FETCH_ENGINE_PERF_EN
    ,
    output logic [15:0]           perf_stall_cnt
`endif
);

    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int TOTAL = W_DEPTH + X_DEPTH;
    localparam int MAXD  = (W_DEPTH > X_DEPTH) ? W_DEPTH : X_DEPTH;
    localparam int IW    = (MAXD > 1) ? $clog2(MAXD) : 1;
    localparam int NW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    if (MEM_LAT < 1 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_err
        $error("fetch_engine: bad MEM_LAT or FIFO_DEPTH");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH_W,
        S_FETCH_X,
        S_DRAIN
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] w_base_q;
    logic [ADDR_WIDTH-1:0] x_base_q;
    logic [IW-1:0]         idx_q;
    logic [NW-1:0]         pop_cnt_q;
    logic                  done_q;
    logic [CW-1:0]         inflight_q;
    logic [CW-1:0]         fifo_cnt_q;
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];

    logic          fetching;
    logic [CW:0]   used;
    logic          accept;
    logic          pop;

    assign fetching = (state_q == S_FETCH_W) || (state_q == S_FETCH_X);
    assign used     = (CW+1)'(fifo_cnt_q) + (CW+1)'(inflight_q);
    assign mem_req  = fetching && (used < (CW+1)'(FIFO_DEPTH));
    assign accept   = mem_rvalid && (inflight_q != '0);
    assign src_vld  = (fifo_cnt_q != '0);
    assign src_data = fifo_q[rd_ptr_q];
    assign pop      = src_vld && src_rdy;
    assign cmd_rdy  = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;

    // read address: phase base plus issue index, wrapping
    always_comb begin
        mem_addr = '0;
        case (state_q)
            S_FETCH_W: mem_addr = w_base_q + ADDR_WIDTH'(idx_q);
            S_FETCH_X: mem_addr = x_base_q + ADDR_WIDTH'(idx_q);
            default:   mem_addr = '0;
        endcase
    end

    // command FSM: issue sequencing and completion on last pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            w_base_q  <= '0;
            x_base_q  <= '0;
            idx_q     <= '0;
            pop_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_vld) begin
                        w_base_q  <= cmd_w_addr;
                        x_base_q  <= cmd_x_addr;
                        idx_q     <= '0;
                        pop_cnt_q <= '0;
                        state_q   <= S_FETCH_W;
                    end
                end
                S_FETCH_W: begin
                    if (mem_req) begin
                        if (idx_q == IW'(W_DEPTH - 1)) begin
                            idx_q   <= '0;
                            state_q <= S_FETCH_X;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                S_FETCH_X: begin
                    if (mem_req) begin
                        if (idx_q == IW'(X_DEPTH - 1)) begin
                            idx_q   <= '0;
                            state_q <= S_DRAIN;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            if (pop) begin
                if (pop_cnt_q == NW'(TOTAL - 1)) begin
                    pop_cnt_q <= '0;
                    done_q    <= 1'b1;
                    state_q   <= S_IDLE;
                end else begin
                    pop_cnt_q <= pop_cnt_q + 1'b1;
                end
            end
        end
    end

    // outstanding read count; responses with nothing pending are stale
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
        end else begin
            case ({mem_req, accept})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // response FIFO; credits guarantee it is never pushed when full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q     <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (accept) begin
                fifo_q[wr_ptr_q] <= mem_rdata;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({accept, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

`ifdef FETCH_ENGINE_PERF_EN
    logic [15:0] perf_q;

    // saturating count of cycles the sink holds off valid data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (cmd_rdy && cmd_vld) begin
            perf_q <= '0;
        end else if (src_vld && !src_rdy && perf_q != 16'hFFFF) begin
            perf_q <= perf_q + 1'b1;
        end
    end

    assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_fetch_engine.sv
// tb_fetch_engine: directed bench for fetch_engine with a
// fixed-latency memory model where memory[a] = a.
module tb_fetch_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_vld = 1'b0;
    logic       cmd_rdy;
    logic [7:0] cmd_w_addr = 8'h00;
    logic [7:0] cmd_x_addr = 8'h00;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_rvalid;
    logic [7:0] mem_rdata;
    logic       src_vld;
    logic       src_rdy = 1'b0;
    logic [7:0] src_data;
    logic       busy;
    logic       done;
`ifdef FETCH_ENGINE_PERF_EN
    logic [15:0] perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    fetch_engine #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(8),
        .W_DEPTH   (16),
        .X_DEPTH   (4),
        .MEM_LAT   (1),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_vld   (cmd_vld),
        .cmd_rdy   (cmd_rdy),
        .cmd_w_addr(cmd_w_addr),
        .cmd_x_addr(cmd_x_addr),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .src_vld   (src_vld),
        .src_rdy   (src_rdy),
        .src_data  (src_data),
        .busy      (busy),
`ifdef FETCH_ENGINE_PERF_EN
        .done      (done),
        .perf_stall_cnt(perf_stall_cnt)
`else
        .done      (done)
`endif
    );

    logic       pv [8] = '{default: 1'b0};
    logic [7:0] pa [8] = '{default: 8'h00};
    logic [2:0] lat_sel = 3'd0;

    // memory: request pipeline, not reset, so stale replies survive
    always @(posedge clk) begin
        pv[0] <= mem_req;
        pa[0] <= mem_addr;
        for (int i = 1; i < 8; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
    end

    assign mem_rvalid = pv[lat_sel];
    assign mem_rdata  = pa[lat_sel];

    int         n_chk = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [7:0] rxq [$];
    int         rx_cyc [$];
    int         done_n = 0;
    int         req_n = 0;
    int         outst = 0;
    int         max_out = 0;
    int         stab_err = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: handshakes, requests, outstanding and stall stability
    always @(negedge clk) begin : mon
        int o;
        if (!rst_n) begin
            outst      <= 0;
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!src_vld || src_data != prev_data))
                stab_err <= stab_err + 1;
            prev_stall <= src_vld && !src_rdy;
            prev_data  <= src_data;
            if (src_vld && src_rdy) begin
                rxq.push_back(src_data);
                rx_cyc.push_back(cyc);
            end
            if (done) done_n <= done_n + 1;
            if (mem_req) req_n <= req_n + 1;
            o = outst + int'(mem_req) - int'(src_vld && src_rdy);
            outst <= o;
            if (o > max_out) max_out <= o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_byte(input logic [7:0] w,
                                            input logic [7:0] x,
                                            input int i);
        logic [7:0] o;
        if (i < 16) o = w + 8'(i);
        else        o = x + 8'(i - 16);
        return o;
    endfunction

    task automatic send_cmd(input logic [7:0] w, input logic [7:0] x);
        cmd_w_addr = w;
        cmd_x_addr = x;
        cmd_vld    = 1'b1;
        tick();
        cmd_vld    = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (done_n < target && k < budget) begin
            tick();
            k++;
        end
        chk("done_seen", 32'(done_n >= target), 1);
    endtask

    task automatic check_stream(input int start, input logic [7:0] w,
                                input logic [7:0] x, input string tag);
        logic [31:0] got;
        chk({tag, "_len"}, 32'(rxq.size() - start >= 20), 1);
        for (int i = 0; i < 20; i++) begin
            if (start + i < rxq.size()) got = 32'(rxq[start+i]);
            else got = 32'hDEAD;
            chk(tag, got, 32'(exp_byte(w, x, i)));
        end
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_cmd_rdy"}, 32'(cmd_rdy), 1);
        chk({tag, "_mem_req"}, 32'(mem_req), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_src_vld"}, 32'(src_vld), 0);
        chk({tag, "_src_data"}, 32'(src_data), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
`ifdef FETCH_ENGINE_PERF_EN
        chk({tag, "_perf"}, 32'(perf_stall_cnt), 0);
`endif
    endtask

    initial begin
        int start;
        int d0;
        int r0;
        int k;

        repeat (3) tick();
        check_reset_outs("rst");
        rst_n = 1'b1;
        tick();

        // basic fetch, MEM_LAT=1, sink always ready
        src_rdy = 1'b1;
        start = rxq.size();
        d0 = done_n;
        send_cmd(8'h10, 8'h40);
        chk("e0_busy", 32'(busy), 1);
        chk("e0_cmd_rdy", 32'(cmd_rdy), 0);
        chk("e0_mem_req", 32'(mem_req), 1);
        chk("e0_mem_addr", 32'(mem_addr), 32'h10);
        tick();
        chk("e1_src_vld", 32'(src_vld), 0);
        chk("e1_mem_addr", 32'(mem_addr), 32'h11);
        tick();
        chk("e2_src_vld", 32'(src_vld), 1);
        chk("e2_src_data", 32'(src_data), 32'h10);
        wait_done(d0 + 1, 100);
        check_stream(start, 8'h10, 8'h40, "basic");
        if (rx_cyc.size() >= start + 20)
            chk("thruput", 32'(rx_cyc[start+19] - rx_cyc[start]), 19);
        else
            chk("thruput", 32'hDEAD, 19);
        tick();
        tick();
        chk("done_once", 32'(done_n - d0), 1);
        chk("idle_rdy", 32'(cmd_rdy), 1);

        // weight base near the top of the address space
        start = rxq.size();
        d0 = done_n;
        send_cmd(8'hF8, 8'h40);
        wait_done(d0 + 1, 100);
        check_stream(start, 8'hF8, 8'h40, "wrap");

        // random backpressure, MEM_LAT=3
        tick();
        lat_sel = 3'd2;
        start = rxq.size();
        d0 = done_n;
        send_cmd(8'h10, 8'h40);
        k = 0;
        while (done_n < d0 + 1 && k < 600) begin
            src_rdy = ($urandom_range(0, 9) >= 3);
            tick();
            k++;
        end
        chk("bp_done", 32'(done_n >= d0 + 1), 1);
        src_rdy = 1'b1;
        check_stream(start, 8'h10, 8'h40, "bp");

        // full stall: credits cap the requests at FIFO_DEPTH
        repeat (4) tick();
        lat_sel = 3'd0;
        src_rdy = 1'b0;
        start = rxq.size();
        d0 = done_n;
        r0 = req_n;
        send_cmd(8'h10, 8'h40);
        repeat (50) tick();
        chk("stall_reqs", 32'(req_n - r0), 4);
        chk("stall_req_low", 32'(mem_req), 0);
        chk("stall_vld", 32'(src_vld), 1);
`ifdef FETCH_ENGINE_PERF_EN
        chk("stall_perf", 32'(perf_stall_cnt >= 16'd46), 1);
`endif
        src_rdy = 1'b1;
        wait_done(d0 + 1, 100);
        check_stream(start, 8'h10, 8'h40, "stall");

        // reset while responses are in flight
        tick();
        lat_sel = 3'd2;
        start = rxq.size();
        d0 = done_n;
        send_cmd(8'h10, 8'h40);
        k = 0;
        while (rxq.size() - start < 7 && k < 100) begin
            tick();
            k++;
        end
        chk("mid_reached7", 32'(rxq.size() - start >= 7), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outs("midrst");
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stale_vld", 32'(src_vld), 0);
            chk("stale_idle", 32'(busy), 0);
        end
        chk("mid_no_done", 32'(done_n - d0), 0);
        start = rxq.size();
        d0 = done_n;
        send_cmd(8'h20, 8'h60);
        wait_done(d0 + 1, 200);
        check_stream(start, 8'h20, 8'h60, "after_rst");

        // back-to-back commands with cmd_vld held high
        repeat (4) tick();
        lat_sel = 3'd0;
        src_rdy = 1'b1;
        start = rxq.size();
        d0 = done_n;
        cmd_w_addr = 8'h10;
        cmd_x_addr = 8'h40;
        cmd_vld = 1'b1;
        tick();
        cmd_w_addr = 8'h80;
        cmd_x_addr = 8'hC0;
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("b2b_done1", 32'(done), 1);
        chk("b2b_rdy", 32'(cmd_rdy), 1);
        @(posedge clk);
        #1;
        chk("b2b_busy", 32'(busy), 1);
        chk("b2b_addr", 32'(mem_addr), 32'h80);
        cmd_vld = 1'b0;
        wait_done(d0 + 2, 100);
        check_stream(start, 8'h10, 8'h40, "b2b_a");
        check_stream(start + 20, 8'h80, 8'hC0, "b2b_b");
        tick();
        tick();
        chk("b2b_dones", 32'(done_n - d0), 2);

        chk("max_outstanding", 32'(max_out <= 4), 1);
        chk("stall_stable", 32'(stab_err), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
